// File: rtl/uart_tx_buffer.sv
// Byte FIFO in front of a UART transmitter: buffers producer bytes and issues
// one registered tx_start pulse per byte, waiting for the transmitter to go idle.
module uart_tx_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     tx_start,
    output logic [7:0]               sdata,
    input  logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE        = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2,
        WAIT = 2'd3
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    state_t        state_reg;
    logic          tx_start_reg;
    logic [7:0]    sdata_reg;

    logic push;
    logic pop;

    // Both decisions look only at registered state, so a pop cannot free a
    // slot for a push in the same cycle.
    assign push = in_valid && (count_reg != FULL_COUNT);
    assign pop  = (state_reg == IDLE) && (count_reg != '0) && !tx_busy;

    assign in_ready = (count_reg != FULL_COUNT);
    assign tx_start = tx_start_reg;
    assign sdata    = sdata_reg;
    assign count    = count_reg;

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    // Pointer width equals log2(DEPTH), so they wrap modulo DEPTH naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + ONE;
                2'b01:   count_reg <= count_reg - ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // HOLD skips one tx_busy sample to cover the transmitter's registered busy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            tx_start_reg <= 1'b0;
            sdata_reg    <= 8'h00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        sdata_reg    <= mem[rd_ptr_reg];
                        tx_start_reg <= 1'b1;
                        state_reg    <= SEND;
                    end
                end
                SEND: begin
                    tx_start_reg <= 1'b0;
                    state_reg    <= HOLD;
                end
                HOLD: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (!tx_busy) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    tx_start_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: reset, latency, ordering, full, push/pop,
// wrap-around and mid-operation reset, against a small busy-model transmitter.
module tb_uart_tx_buffer;

    localparam int DEPTH = 16;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       tx_start;
    logic [7:0] sdata;
    logic       tx_busy;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int busy_len = 0;
    logic force_busy = 1'b0;
    logic prev_start = 1'b0;
    int wide_cnt = 0;
    logic [7:0] rx_q[$];
    int rx_cyc[$];

    uart_tx_buffer #(.DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .tx_start (tx_start),
        .sdata    (sdata),
        .tx_busy  (tx_busy),
        .count    (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Transmitter model: busy is a flop loaded on tx_start, ORed with tx_start.
    always @(posedge clock) begin
        if (tx_start) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = force_busy | tx_start | (busy_cnt != 0);

    always @(negedge clock) begin
        if (tx_start) begin
            rx_q.push_back(sdata);
            rx_cyc.push_back(cyc);
            if (prev_start) wide_cnt <= wide_cnt + 1;
        end
        prev_start <= tx_start;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Holds in_valid until the byte is taken; bounded wait.
    task automatic push(input logic [7:0] b);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("push_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (rx_q.size() < n) check("pulse_timeout", 32'(rx_q.size()), 32'(n));
    endtask

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_q.size()) return 32'(rx_q[i]);
        return 32'hxxxx_xxxx;
    endfunction

    function automatic int gap_at(input int i);
        if (i + 1 < rx_cyc.size()) return rx_cyc[i+1] - rx_cyc[i];
        return 0;
    endfunction

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        // Asynchronous reset values before any clock edge
        check("rst_count", 32'(count), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_sdata", 32'(sdata), 32'h00);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Single byte latency
        push(8'hA5);
        check("single_count_after_push", 32'(count), 32'd1);
        check("single_no_early_start", 32'(tx_start), 32'd0);
        tick();
        check("single_start", 32'(tx_start), 32'd1);
        check("single_sdata", 32'(sdata), 32'hA5);
        check("single_count_zero", 32'(count), 32'd0);
        tick();
        check("single_start_cleared", 32'(tx_start), 32'd0);
        check("single_sdata_held", 32'(sdata), 32'hA5);
        repeat (6) tick();
        check("single_pulse_count", 32'(rx_q.size()), 32'd1);

        // Burst order with long busy
        rx_q.delete();
        rx_cyc.delete();
        busy_len = 20;
        for (int i = 1; i <= 5; i++) push(8'(i));
        wait_pulses(5, 400);
        for (int i = 0; i < 5; i++) check($sformatf("burst_byte%0d", i), rx_at(i), 32'(i + 1));
        for (int i = 0; i < 4; i++) check($sformatf("burst_gap%0d", i), 32'(gap_at(i) > 20), 32'd1);
        repeat (30) tick();

        // Full buffer
        rx_q.delete();
        rx_cyc.delete();
        busy_len   = 0;
        force_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) push(8'h10 + 8'(i));
        check("full_count", 32'(count), 32'(DEPTH));
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h10 + 8'(DEPTH);
        repeat (3) tick();
        check("full_no_extra_push", 32'(count), 32'(DEPTH));
        check("full_no_pop_while_busy", 32'(rx_q.size()), 32'd0);
        force_busy = 1'b0;
        push(8'h10 + 8'(DEPTH));
        wait_pulses(DEPTH + 1, 600);
        for (int i = 0; i <= DEPTH; i++) check($sformatf("full_byte%0d", i), rx_at(i), 32'(8'h10 + 8'(i)));
        repeat (10) tick();

        // Simultaneous push and pop
        rx_q.delete();
        rx_cyc.delete();
        busy_len   = 3;
        force_busy = 1'b1;
        push(8'h31);
        push(8'h32);
        push(8'h33);
        check("pp_count_before", 32'(count), 32'd3);
        force_busy = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'h34;
        tick();
        in_valid = 1'b0;
        check("pp_count_same", 32'(count), 32'd3);
        check("pp_start", 32'(tx_start), 32'd1);
        check("pp_sdata", 32'(sdata), 32'h31);
        wait_pulses(4, 200);
        for (int i = 0; i < 4; i++) check($sformatf("pp_byte%0d", i), rx_at(i), 32'(8'h31 + 8'(i)));
        repeat (10) tick();

        // Wrap: 3*DEPTH bytes through the model transmitter
        rx_q.delete();
        rx_cyc.delete();
        busy_len = 1;
        for (int i = 0; i < 3 * DEPTH; i++) push(8'h40 + 8'(i));
        wait_pulses(3 * DEPTH, 1000);
        for (int i = 0; i < 3 * DEPTH; i++) check($sformatf("wrap_byte%0d", i), rx_at(i), 32'(8'h40 + 8'(i)));
        for (int i = 0; i < 3 * DEPTH - 1; i++) check($sformatf("wrap_gap%0d", i), 32'(gap_at(i) >= 4), 32'd1);
        repeat (10) tick();
        check("wrap_count_drained", 32'(count), 32'd0);
        check("wrap_no_extra", 32'(rx_q.size()), 32'(3 * DEPTH));

        // Reset while in WAIT with five bytes queued
        rx_q.delete();
        rx_cyc.delete();
        busy_len   = 0;
        force_busy = 1'b1;
        for (int i = 0; i < 6; i++) push(8'h50 + 8'(i));
        check("mid_count6", 32'(count), 32'd6);
        force_busy = 1'b0;
        tick();
        force_busy = 1'b1;
        check("mid_pop_start", 32'(tx_start), 32'd1);
        check("mid_count5", 32'(count), 32'd5);
        repeat (3) tick();
        check("mid_count5_wait", 32'(count), 32'd5);
        reset = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_tx_start", 32'(tx_start), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_sdata", 32'(sdata), 32'h00);
        tick();
        reset = 1'b1;
        rx_q.delete();
        rx_cyc.delete();
        force_busy = 1'b0;
        repeat (20) tick();
        check("post_rst_no_pulse", 32'(rx_q.size()), 32'd0);
        check("post_rst_count", 32'(count), 32'd0);
        push(8'h77);
        wait_pulses(1, 50);
        check("post_rst_byte", rx_at(0), 32'h77);
        repeat (6) tick();
        check("pulse_width_one", 32'(wide_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
